// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter sharing one uart_tx serializer between NUM_REQ
//   requesters. The winning requester's byte is latched and launched with a
//   single tx_start pulse. Ownership is held until uart_tx reports tx_done.
//
//   Optional watchdog: define UART_TX_ARB_TIMEOUT_EN to abort a frame that
//   sits in WAIT_DONE for TIMEOUT_CYCLES cycles. Without it, WAIT_DONE waits
//   indefinitely and err_timeout is tied low.
//
// Ports
//   clk          system clock, all logic on posedge
//   reset        synchronous active-high reset
//   req          per-requester level request
//   req_data     requester i payload at [i*DATA_WIDTH +: DATA_WIDTH]
//   grant        one-hot pulse, requester's byte consumed
//   tx_start     one-cycle pulse to uart_tx
//   tx_data      payload to uart_tx, held until frame done
//   tx_busy      uart_tx shifting a frame
//   tx_done      uart_tx end-of-frame pulse
//   owner        index of current/last granted requester
//   busy         high whenever the FSM is not IDLE
//   frame_count  completed frames, wraps at 16 bits
//   err_timeout  one-cycle pulse on watchdog abort
//
// state     | meaning
// IDLE      | waiting for a request while uart_tx is idle
// LAUNCH    | grant and tx_start asserted for this single cycle
// WAIT_DONE | frame in flight, waiting for tx_done
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          tx_start,
  output logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_busy,
  input  logic                          tx_done,
  output logic [$clog2(NUM_REQ)-1:0]    owner,
  output logic                          busy,
  output logic [15:0]                   frame_count,
  output logic                          err_timeout
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] last;
  logic [IDX_W-1:0] winner;
  logic             arb_go;
  logic             timeout_hit;

  // Round-robin pick: the lowest requester above 'last' wins; if there is
  // none, wrap around to the lowest requester at or below 'last'. The second
  // loop runs after the first so its result takes precedence.
  always_comb begin
    winner = last;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req[j] && (j <= int'(last))) begin
        winner = IDX_W'(j);
      end
    end
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req[j] && (j > int'(last))) begin
        winner = IDX_W'(j);
      end
    end
  end

  assign arb_go = (state == IDLE) && (|req) && !tx_busy;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (arb_go) begin
          state_next = LAUNCH;
        end
      end
      LAUNCH: begin
        state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (tx_done || timeout_hit) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs: grant/tx_start are decoded from LAUNCH, so they are exactly one
  // cycle wide and always point at the requester latched on entry.
  always_comb begin
    grant    = '0;
    tx_start = 1'b0;
    busy     = (state != IDLE);
    if (state == LAUNCH) begin
      grant[owner] = 1'b1;
      tx_start     = 1'b1;
    end
  end

  // Datapath: payload, owner, round-robin pointer and frame counter
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_data     <= '0;
      owner       <= '0;
      last        <= IDX_W'(NUM_REQ - 1);
      frame_count <= '0;
    end else begin
      if (arb_go) begin
        tx_data <= req_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
        owner   <= winner;
        last    <= winner;
      end
      if ((state == WAIT_DONE) && tx_done) begin
        frame_count <= frame_count + 16'd1;
      end
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] wait_cnt;

  // Counter is held at zero outside WAIT_DONE, so it starts from zero on
  // every entry. A tx_done in the terminal cycle takes precedence.
  assign timeout_hit = (state == WAIT_DONE) && !tx_done &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt    <= '0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= timeout_hit;
      if (state != WAIT_DONE) begin
        wait_cnt <= '0;
      end else begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
    end
  end
`else
  logic unused_timeout_cfg;

  assign timeout_hit        = 1'b0;
  assign err_timeout        = 1'b0;
  // Keeps the watchdog length referenced in builds without the watchdog.
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DW      = 8;
  localparam int TO      = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ*DW-1:0] req_data;
  logic [NUM_REQ-1:0]   grant;
  logic                 tx_start;
  logic [DW-1:0]        tx_data;
  logic                 tx_busy;
  logic                 tx_done;
  logic [1:0]           owner;
  logic                 busy;
  logic [15:0]          frame_count;
  logic                 err_timeout;

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ),
    .DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .req_data(req_data),
    .grant(grant),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .tx_busy(tx_busy),
    .tx_done(tx_done),
    .owner(owner),
    .busy(busy),
    .frame_count(frame_count),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    int          busy_hold;
    logic [3:0]  exp_grant;
    logic [7:0]  exp_data;
    logic [1:0]  exp_owner;
    logic [15:0] exp_fc;
  } vec_t;

  typedef struct packed {
    logic [3:0] g;
    logic [7:0] d;
    logic [1:0] o;
  } exp_t;

  vec_t vecs[8];
  exp_t sb_q[$];
  exp_t mon_e;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every grant/tx_start the DUT produces must match the oldest
  // pending expectation; any launch with nothing pending is an error.
  always @(negedge clk) begin
    if (!reset && (tx_start || (grant != '0))) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: grant=0x%0h tx_start=%0b with no pending expectation",
                 grant, tx_start);
      end else begin
        mon_e = sb_q.pop_front();
        if (({grant, tx_data, owner} !== {mon_e.g, mon_e.d, mon_e.o}) || (tx_start !== 1'b1)) begin
          errors++;
          $display("FAIL sb_launch: got grant=0x%0h data=0x%0h owner=%0d start=%0b expected grant=0x%0h data=0x%0h owner=%0d start=1",
                   grant, tx_data, owner, tx_start, mon_e.g, mon_e.d, mon_e.o);
        end
      end
    end
  end

  task automatic run_vec(input vec_t v);
    req      = v.req;
    req_data = v.data;
    tx_busy  = (v.busy_hold > 0);
    for (int c = 0; c < v.busy_hold; c++) begin
      tick();
      chk("hold_no_start", {31'd0, tx_start}, 32'd0);
      chk("hold_idle", {31'd0, busy}, 32'd0);
    end
    tx_busy = 1'b0;
    sb_q.push_back({v.exp_grant, v.exp_data, v.exp_owner});
    tick();
    chk("vec_start", {31'd0, tx_start}, 32'd1);
    chk("vec_grant", {28'd0, grant}, {28'd0, v.exp_grant});
    chk("vec_data", {24'd0, tx_data}, {24'd0, v.exp_data});
    chk("vec_owner", {30'd0, owner}, {30'd0, v.exp_owner});
    req = '0;
    tick();
    chk("vec_grant_clr", {28'd0, grant}, 32'd0);
    chk("vec_busy_wait", {31'd0, busy}, 32'd1);
    tx_busy = 1'b1;
    repeat (3) tick();
    chk("vec_data_hold", {24'd0, tx_data}, {24'd0, v.exp_data});
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tx_busy = 1'b0;
    chk("vec_busy_end", {31'd0, busy}, 32'd0);
    chk("vec_fc", {16'd0, frame_count}, {16'd0, v.exp_fc});
  endtask

  logic [7:0] rot_data [5];
  logic [3:0] rot_grant[5];

  initial begin
    vecs[0] = '{4'b0001, 32'h000000A5, 0, 4'b0001, 8'hA5, 2'd0, 16'd1};
    vecs[1] = '{4'b1001, 32'h44332211, 0, 4'b1000, 8'h44, 2'd3, 16'd2};
    vecs[2] = '{4'b0011, 32'hD4C3B2A1, 0, 4'b0001, 8'hA1, 2'd0, 16'd3};
    vecs[3] = '{4'b0011, 32'hD4C3B2A1, 0, 4'b0010, 8'hB2, 2'd1, 16'd4};
    vecs[4] = '{4'b0101, 32'h0F0E0D0C, 3, 4'b0100, 8'h0E, 2'd2, 16'd5};
    vecs[5] = '{4'b0100, 32'h5A6B7C8D, 0, 4'b0100, 8'h6B, 2'd2, 16'd6};
    vecs[6] = '{4'b1010, 32'hF0E1D2C3, 2, 4'b1000, 8'hF0, 2'd3, 16'd7};
    vecs[7] = '{4'b1110, 32'h01020304, 0, 4'b0010, 8'h03, 2'd1, 16'd8};
    rot_data  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    rot_grant = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    reset    = 1'b1;
    req      = '0;
    req_data = '0;
    tx_busy  = 1'b0;
    tx_done  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_grant", {28'd0, grant}, 32'd0);
    chk("rst_start", {31'd0, tx_start}, 32'd0);
    chk("rst_data", {24'd0, tx_data}, 32'd0);
    chk("rst_owner", {30'd0, owner}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_fc", {16'd0, frame_count}, 32'd0);
    chk("rst_err", {31'd0, err_timeout}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i]);
    end

    // Stray tx_done in IDLE, then a request withdrawn while uart_tx is busy
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("stray_fc", {16'd0, frame_count}, 32'd8);
    chk("stray_busy", {31'd0, busy}, 32'd0);
    req     = 4'b1000;
    tx_busy = 1'b1;
    tick();
    req     = '0;
    tx_busy = 1'b0;
    repeat (3) begin
      tick();
      chk("withdraw_start", {31'd0, tx_start}, 32'd0);
      chk("withdraw_grant", {28'd0, grant}, 32'd0);
    end
    chk("withdraw_fc", {16'd0, frame_count}, 32'd8);

    // All requesters held after reset: strict rotation, tx_start two cycles after tx_done
    reset = 1'b1;
    tick();
    reset    = 1'b0;
    req      = 4'b1111;
    req_data = 32'h44332211;
    for (int k = 0; k < 5; k++) begin
      sb_q.push_back({rot_grant[k], rot_data[k], 2'(k % 4)});
      tick();
      chk("rot_start", {31'd0, tx_start}, 32'd1);
      chk("rot_data", {24'd0, tx_data}, {24'd0, rot_data[k]});
      tick();
      chk("rot_grant_pulse", {28'd0, grant}, 32'd0);
      tx_busy = 1'b1;
      tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      tx_busy = 1'b0;
      if (k == 4) req = '0;
      chk("rot_gap_idle", {31'd0, tx_start}, 32'd0);
      chk("rot_gap_busy", {31'd0, busy}, 32'd0);
    end
    chk("rot_fc", {16'd0, frame_count}, 32'd5);

    // Reset while in WAIT_DONE with requester 1 pending
    req      = 4'b0001;
    req_data = 32'h0000BBAA;
    sb_q.push_back({4'b0001, 8'hAA, 2'd0});
    tick();
    chk("rstw_start", {31'd0, tx_start}, 32'd1);
    req = '0;
    tick();
    req     = 4'b0010;
    tx_busy = 1'b1;
    reset   = 1'b1;
    tick();
    chk("rstw_grant", {28'd0, grant}, 32'd0);
    chk("rstw_start0", {31'd0, tx_start}, 32'd0);
    chk("rstw_data", {24'd0, tx_data}, 32'd0);
    chk("rstw_owner", {30'd0, owner}, 32'd0);
    chk("rstw_busy", {31'd0, busy}, 32'd0);
    chk("rstw_fc", {16'd0, frame_count}, 32'd0);
    reset   = 1'b0;
    tx_busy = 1'b0;
    sb_q.push_back({4'b0010, 8'hBB, 2'd1});
    tick();
    chk("rstw_first_grant", {28'd0, grant}, 32'h2);
    chk("rstw_first_owner", {30'd0, owner}, 32'd1);
    req = '0;
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("rstw_fc1", {16'd0, frame_count}, 32'd1);

    // Frame whose tx_done never arrives
    req      = 4'b0100;
    req_data = 32'h00CC0000;
    sb_q.push_back({4'b0100, 8'hCC, 2'd2});
    tick();
    req = '0;
    tick();
`ifdef UART_TX_ARB_TIMEOUT_EN
    for (int c = 0; c < TO - 1; c++) begin
      tick();
      chk("to_err_early", {31'd0, err_timeout}, 32'd0);
    end
    tick();
    chk("to_err_pulse", {31'd0, err_timeout}, 32'd1);
    chk("to_busy_drop", {31'd0, busy}, 32'd0);
    chk("to_fc", {16'd0, frame_count}, 32'd1);
    tick();
    chk("to_err_clear", {31'd0, err_timeout}, 32'd0);
`else
    for (int c = 0; c < 40; c++) begin
      tick();
      chk("nto_busy", {31'd0, busy}, 32'd1);
    end
    chk("nto_err", {31'd0, err_timeout}, 32'd0);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("nto_fc", {16'd0, frame_count}, 32'd2);
`endif

    tick();
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
